// File: rtl/counter_6b.sv
// counter_6b: enabled, prescaled up-counter for the LED bank; wraps or saturates at MAX_VAL.
// Define COUNTER_6B_TC_EN to add the registered one-cycle terminal-count output tc.
module counter_6b #(
    parameter int WIDTH    = 6,
    parameter int PRESCALE = 1,
    parameter int MAX_VAL  = (2 ** WIDTH) - 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en,
`ifdef COUNTER_6B_TC_EN
    output logic             tc,
`endif
    output logic [WIDTH-1:0] cnt
);

    localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);

    generate
        if ((PRESCALE < 1) || (MAX_VAL >= (2 ** WIDTH))) begin : g_param_check
            $error("counter_6b: PRESCALE must be >= 1 and MAX_VAL < 2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] r_cnt;
    logic [PW-1:0]    r_pre;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [PW-1:0]    w_pre_nxt;
    logic             w_adv;
    logic             w_at_max;

    // Prescaler stepping and advance/wrap/saturate selection for the next count.
    always_comb begin
        w_adv     = 1'b0;
        w_pre_nxt = r_pre;
        w_cnt_nxt = r_cnt;
        w_at_max  = (r_cnt == MAX_C);
        if (cnt_en) begin
            if (r_pre == PRE_LAST) begin
                w_adv     = 1'b1;
                w_pre_nxt = {PW{1'b0}};
            end else begin
                w_pre_nxt = r_pre + PW'(1'b1);
            end
        end else begin
            w_pre_nxt = r_pre;
        end
        if (w_adv) begin
            if (!w_at_max) begin
                w_cnt_nxt = r_cnt + WIDTH'(1'b1);
            end else if (SATURATE) begin
                w_cnt_nxt = r_cnt;
            end else begin
                w_cnt_nxt = {WIDTH{1'b0}};
            end
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Count and prescaler state; reset overrides enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= {WIDTH{1'b0}};
            r_pre <= {PW{1'b0}};
        end else begin
            r_cnt <= w_cnt_nxt;
            r_pre <= w_pre_nxt;
        end
    end

    assign cnt = r_cnt;

`ifdef COUNTER_6B_TC_EN
    logic r_tc;
    logic r_sat_done;
    logic w_tc_nxt;

    // A saturating counter only reports its first advance attempt at the limit.
    always_comb begin
        w_tc_nxt = w_adv && w_at_max && !(SATURATE && r_sat_done);
    end

    // Terminal-count pulse register and the saturate "already reported" flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tc       <= 1'b0;
            r_sat_done <= 1'b0;
        end else begin
            r_tc <= w_tc_nxt;
            if (w_tc_nxt) begin
                r_sat_done <= 1'b1;
            end else begin
                r_sat_done <= r_sat_done;
            end
        end
    end

    assign tc = r_tc;
`endif

endmodule

// File: tb/tb_counter_6b.sv
// Self-checking bench for counter_6b: default, saturating (MAX_VAL=10) and PRESCALE=4 instances.
// Define COUNTER_6B_TC_EN on both bench and RTL to also check the tc pulse.
module tb_counter_6b;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d = 1'b0, en_d = 1'b0;
    logic rst_s = 1'b0, en_s = 1'b0;
    logic rst_p = 1'b0, en_p = 1'b0;
    logic [5:0] cnt_d, cnt_s, cnt_p;
`ifdef COUNTER_6B_TC_EN
    logic tc_d, tc_s, tc_p;
`endif

    counter_6b u_dut_d (
        .clk    (clk),
        .rst    (rst_d),
        .cnt_en (en_d),
`ifdef COUNTER_6B_TC_EN
        .tc     (tc_d),
`endif
        .cnt    (cnt_d)
    );

    counter_6b #(.SATURATE(1'b1), .MAX_VAL(10)) u_dut_s (
        .clk    (clk),
        .rst    (rst_s),
        .cnt_en (en_s),
`ifdef COUNTER_6B_TC_EN
        .tc     (tc_s),
`endif
        .cnt    (cnt_s)
    );

    counter_6b #(.PRESCALE(4)) u_dut_p (
        .clk    (clk),
        .rst    (rst_p),
        .cnt_en (en_p),
`ifdef COUNTER_6B_TC_EN
        .tc     (tc_p),
`endif
        .cnt    (cnt_p)
    );

    typedef struct {
        logic       r;
        logic       e;
        logic [5:0] x;
    } vec_t;

    typedef struct {
        int         sel;
        logic [5:0] x;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [5:0] pick(input int sel);
        case (sel)
            0:       return cnt_d;
            1:       return cnt_s;
            default: return cnt_p;
        endcase
    endfunction

    task automatic chk(input logic [5:0] act, input logic [5:0] req, input string nm);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Drive one cycle of stimulus on the selected instance, queue the expectation, compare after the edge.
    task automatic step(input int sel, input logic r, input logic e, input logic [5:0] x, input string nm);
        exp_t ev;
        exp_t got;
        @(negedge clk);
        case (sel)
            0:       begin rst_d = r; en_d = e; end
            1:       begin rst_s = r; en_s = e; end
            default: begin rst_p = r; en_p = e; end
        endcase
        ev.sel = sel;
        ev.x   = x;
        ev.nm  = nm;
        sb.push_back(ev);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk(pick(got.sel), got.x, got.nm);
    endtask

    initial begin
        vec_t tbl[15];
        for (int i = 0; i < 2; i++)   tbl[i] = '{1'b1, 1'b0, 6'd0};
        for (int i = 2; i < 7; i++)   tbl[i] = '{1'b1, 1'b1, 6'd0};
        for (int i = 7; i < 12; i++)  tbl[i] = '{1'b0, 1'b1, 6'(i - 6)};
        for (int i = 12; i < 15; i++) tbl[i] = '{1'b0, 1'b0, 6'd5};

        // reset priority, basic count, hold
        for (int i = 0; i < 15; i++) begin
            step(0, tbl[i].r, tbl[i].e, tbl[i].x, $sformatf("vec%0d", i));
        end

        // full wrap from 0, one edge past the wrap
        step(0, 1'b1, 1'b0, 6'd0, "wrap_rst");
        for (int k = 1; k <= 65; k++) begin
            step(0, 1'b0, 1'b1, 6'(k % 64), $sformatf("wrap_e%0d", k));
`ifdef COUNTER_6B_TC_EN
            if (k == 63) chk({5'd0, tc_d}, 6'd0, "tc_before_wrap");
            if (k == 64) chk({5'd0, tc_d}, 6'd1, "tc_after_wrap");
            if (k == 65) chk({5'd0, tc_d}, 6'd0, "tc_one_cycle");
`endif
        end

        // reset mid-count at 37 with enable held high
        for (int k = 2; k <= 37; k++) begin
            step(0, 1'b0, 1'b1, 6'(k), "to_37");
        end
        step(0, 1'b1, 1'b1, 6'd0, "mid_rst");
        step(0, 1'b0, 1'b1, 6'd1, "post_rst");

        // saturate at 10
        step(1, 1'b1, 1'b0, 6'd0, "sat_rst");
        for (int k = 1; k <= 15; k++) begin
            step(1, 1'b0, 1'b1, 6'((k > 10) ? 10 : k), $sformatf("sat_e%0d", k));
`ifdef COUNTER_6B_TC_EN
            if (k == 10) chk({5'd0, tc_s}, 6'd0, "tc_sat_arrive");
            if (k == 11) chk({5'd0, tc_s}, 6'd1, "tc_sat_first");
            if (k == 12) chk({5'd0, tc_s}, 6'd0, "tc_sat_once");
`endif
        end

        // prescale by 4
        step(2, 1'b1, 1'b0, 6'd0, "pre_rst");
        for (int k = 1; k <= 12; k++) begin
            step(2, 1'b0, 1'b1, 6'(k / 4), $sformatf("pre_e%0d", k));
        end

        // enable gap inside a prescale period
        step(2, 1'b1, 1'b1, 6'd0, "gap_rst");
        step(2, 1'b0, 1'b1, 6'd0, "gap_e1");
        step(2, 1'b0, 1'b1, 6'd0, "gap_e2");
        for (int k = 0; k < 3; k++) begin
            step(2, 1'b0, 1'b0, 6'd0, "gap_hold");
        end
        step(2, 1'b0, 1'b1, 6'd0, "gap_e3");
        step(2, 1'b0, 1'b1, 6'd1, "gap_e4");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/counter_6b.md
Name:
counter_6b

Overview:
- Synchronous enabled up-counter driving the board LED bank; default 6-bit output.
- Counts once per prescale period while `cnt_en` is high and holds otherwise.
- Wraps at a programmable maximum, or saturates there.
- Sits between the board clock/reset and the LED outputs; one instance per counter display.

Parameters:
- WIDTH, 6: counter width in bits; sets the width of `cnt`.
- PRESCALE, 1: number of enabled clock cycles per count step. Must be >= 1; 1 means step on every enabled cycle.
- MAX_VAL, 2**WIDTH-1: terminal count value. Must be < 2**WIDTH.
- SATURATE, 0: at MAX_VAL, 0 = wrap to 0, 1 = hold at MAX_VAL.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- cnt_en  input  1  count enable; high = advance, low = hold.
- cnt  output  WIDTH  current count value, driven directly from a register.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: on a rising `clk` edge with `rst`=1, `cnt` <= 0 and the internal prescaler counter `pre` <= 0.
  - `rst` has priority over `cnt_en`.
  - No asynchronous path.
  - State before the first reset is undefined.
- Hold: `rst`=0 and `cnt_en`=0 -> `cnt` and `pre` keep their values.
- Enabled step: `rst`=0 and `cnt_en`=1:
  - if `pre` == PRESCALE-1: `pre` <= 0 and `cnt` advances;
  - else: `pre` <= `pre`+1 and `cnt` holds.
  - With PRESCALE=1, `cnt` advances on every enabled edge.
- Advance rule:
  - `cnt` != MAX_VAL -> `cnt` <= `cnt`+1.
  - `cnt` == MAX_VAL and SATURATE=0 -> `cnt` <= 0.
  - `cnt` == MAX_VAL and SATURATE=1 -> `cnt` holds at MAX_VAL.
- Latency: `cnt` reflects an advance on the same edge that samples the qualifying `cnt_en`; output is registered, no combinational path from inputs.
- Enable gaps: dropping `cnt_en` mid prescale period freezes `pre`; the period resumes where it stopped when `cnt_en` returns high.
- Reset mid-count: clears `cnt` and `pre` on the next edge regardless of `cnt_en`.
  - Deasserting `rst` with `cnt_en`=1 gives the first advance PRESCALE edges later.
- Widths:
  - `pre` is ceil(log2(PRESCALE)) bits, minimum 1.
  - Arithmetic is unsigned, with no overflow beyond WIDTH.
- Elaboration: PRESCALE < 1 or MAX_VAL >= 2**WIDTH is an elaboration error.

Optional Feature:
- Macro: COUNTER_6B_TC_EN.
- Defined: adds output port `tc` (1 bit, output).
  - `tc` is high for exactly the one cycle following an edge where `cnt` advanced from MAX_VAL (wrap or saturate event).
  - Registered; cleared to 0 by reset.
  - In SATURATE=1 mode, `tc` pulses only on the first arrival-at-limit advance attempt, not every period.
- Not defined: no `tc` port, no related logic; port list is exactly `clk`, `rst`, `cnt_en`, `cnt`.

Test Plan:
- Reset priority: `rst`=1 with `cnt_en`=0, 2 edges -> `cnt`=0. Then `rst`=1 with `cnt_en`=1 for 5 edges -> `cnt` stays 0.
- Basic count (PRESCALE=1): `rst`=0, `cnt_en`=1 for 5 edges -> `cnt` goes 1,2,3,4,5. Then `cnt_en`=0 for 3 edges -> `cnt` holds 5.
- Wrap (defaults): run from 0 with `cnt_en`=1 for 64 edges -> `cnt` 63 on edge 63, 0 on edge 64. With COUNTER_6B_TC_EN, `tc`=1 for one cycle after edge 64.
- Saturate (SATURATE=1, MAX_VAL=10): 15 enabled edges from 0 -> `cnt` reaches 10 on edge 10 and stays 10 through edge 15.
- Prescale (PRESCALE=4): 12 enabled edges from reset -> `cnt` = 1 after edge 4, 2 after 8, 3 after 12.
  - Same run with `cnt_en` low for 3 cycles after edge 2 -> next advance lands 4 enabled edges after reset, i.e. 7 edges after reset.
- Reset mid-count: `cnt`=37, assert `rst` for 1 edge with `cnt_en`=1 -> `cnt`=0. Release `rst` -> `cnt` is 1 on the next edge (PRESCALE=1).
